// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: holds one request against a variable-latency data
// memory, stalls the pipeline meanwhile, and aligns/extends loads or replicates stores.
module mem_access_ctrl #(
  parameter int TAM_DATO = 32,
  parameter int TAM_DIR  = 32,
  parameter int TAM_MASK = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic                  i_is_unsigned,
  input  logic [TAM_MASK-1:0]   i_mascara,
  input  logic [TAM_DIR-1:0]    i_addr,
  input  logic [TAM_DATO-1:0]   i_wdata,
  output logic                  o_stall,
  output logic                  o_rdata_valid,
  output logic [TAM_DATO-1:0]   o_rdata,
  output logic                  o_misaligned,
  output logic                  o_bus_error,
  output logic                  o_mem_en,
  output logic [3:0]            o_mem_we,
  output logic [TAM_DIR-3:0]    o_mem_addr,
  output logic [TAM_DATO-1:0]   o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [TAM_DATO-1:0]   i_mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TAM_DIR-1:0]  addr_q, addr_d;
  logic [TAM_MASK-1:0] mask_q, mask_d;
  logic                uns_q, uns_d;
  logic                is_load_q, is_load_d;
  logic                err_q, err_d;
  logic [3:0]          we_q, we_d;
  logic [TAM_DATO-1:0] wdata_q, wdata_d;
  logic [TAM_DATO-1:0] rdata_q, rdata_d;

  logic                start;
  logic                misaligned;
  logic [3:0]          req_we;
  logic [TAM_DATO-1:0] req_wdata;
  logic [TAM_DATO-1:0] lane;
  logic [TAM_DATO-1:0] load_ext;
  logic [CW-1:0]       cnt_inc;

  assign start      = i_valid & (i_mem_read | i_mem_write);
  assign misaligned = ((i_mascara == 2'b01) & i_addr[0]) | (i_mascara[1] & (|i_addr[1:0]));
  assign cnt_inc    = cnt_q + CW'(1);

  // Byte enables and lane-replicated data for the incoming request; loads drive no enables.
  always_comb begin
    req_we    = 4'b0000;
    req_wdata = i_wdata;
    case (i_mascara)
      2'b00: begin
        req_we    = 4'b0001 << i_addr[1:0];
        req_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        req_we    = i_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{i_wdata[15:0]}};
      end
      default: req_we = 4'b1111;
    endcase
    if (!i_mem_write) req_we = 4'b0000;
  end

  assign lane = i_mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (mask_q)
      2'b00:   load_ext = {{24{~uns_q & lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{16{~uns_q & lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // NOTE: every next-state value defaults to its current flop so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    uns_d     = uns_q;
    is_load_d = is_load_q;
    err_d     = err_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (misaligned) begin
            state_d = S_FAULT;
          end else begin
            state_d   = S_ACCESS;
            addr_d    = i_addr;
            mask_d    = i_mascara;
            uns_d     = i_is_unsigned;
            is_load_d = ~i_mem_write;
            we_d      = req_we;
            wdata_d   = req_wdata;
            err_d     = 1'b0;
            cnt_d     = '0;
          end
        end
      end
      S_ACCESS: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (i_mem_ack) begin
          state_d = S_DONE;
          if (is_load_q) rdata_d = load_ext;
        end else if (cnt_inc == TIMEOUT_C) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      uns_q     <= 1'b0;
      is_load_q <= 1'b0;
      err_q     <= 1'b0;
      we_q      <= 4'b0000;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      uns_q     <= uns_d;
      is_load_q <= is_load_d;
      err_q     <= err_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  assign o_stall       = (state_q == S_ACCESS) | ((state_q == S_IDLE) & start & ~misaligned);
  assign o_mem_en      = (state_q == S_ACCESS);
  assign o_mem_we      = o_mem_en ? we_q : 4'b0000;
  assign o_mem_addr    = o_mem_en ? addr_q[TAM_DIR-1:2] : '0;
  assign o_mem_wdata   = o_mem_en ? wdata_q : '0;
  assign o_rdata_valid = (state_q == S_DONE) & is_load_q & ~err_q;
  assign o_bus_error   = (state_q == S_DONE) & err_q;
  assign o_misaligned  = (state_q == S_FAULT);
  assign o_rdata       = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed table of the key load/store cases,
// multi-cycle reset/ack corners, then random transactions against a transaction-level model.
module tb_mem_access_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_valid, i_mem_read, i_mem_write, i_is_unsigned;
  logic [1:0]  i_mascara;
  logic [31:0] i_addr, i_wdata;
  logic        o_stall, o_rdata_valid, o_misaligned, o_bus_error, o_mem_en;
  logic [31:0] o_rdata, o_mem_wdata;
  logic [3:0]  o_mem_we;
  logic [29:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TAM_DATO(32), .TAM_DIR(32), .TAM_MASK(2), .TIMEOUT(TO)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_valid(i_valid), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_is_unsigned(i_is_unsigned), .i_mascara(i_mascara),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_stall(o_stall), .o_rdata_valid(o_rdata_valid),
    .o_rdata(o_rdata), .o_misaligned(o_misaligned), .o_bus_error(o_bus_error),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  typedef struct {
    logic        rd, wr, u;
    logic [1:0]  mask;
    logic [31:0] addr, wdata, word;
    int          delay;
    logic [3:0]  exp_we;
    logic [31:0] exp_wd;
    logic        exp_mis;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " stall"}, 32'(o_stall), 0);
    check({tag, " mem_en"}, 32'(o_mem_en), 0);
    check({tag, " we"}, 32'(o_mem_we), 0);
    check({tag, " mem_addr"}, 32'(o_mem_addr), 0);
    check({tag, " mem_wdata"}, o_mem_wdata, 0);
    check({tag, " rdata"}, o_rdata, 0);
    check({tag, " pulses"}, {29'd0, o_rdata_valid, o_misaligned, o_bus_error}, 0);
  endtask

  // Size/alignment/extension rules computed from the byte-level definition with plain arithmetic.
  function automatic void model(input logic wr, input logic u, input logic [1:0] mask,
                                input logic [31:0] addr, wdata, word, input int delay,
                                output logic [3:0] exp_we, output logic [31:0] exp_wd,
                                output logic exp_mis, inout logic [31:0] rdata);
    int size, b;
    longint v, bits;
    size = (mask == 2'b00) ? 1 : (mask == 2'b01) ? 2 : 4;
    b    = int'(addr % 4);
    exp_mis = (addr % size) != 0;
    exp_we  = wr ? 4'(((1 << size) - 1) << b) : 4'b0000;
    v = longint'(wdata) % (longint'(1) << (8 * size));
    exp_wd = (size == 1) ? 32'(v * 64'h01010101) : (size == 2) ? 32'(v * 64'h00010001) : wdata;
    if (exp_mis) return;
    if (delay >= TO) begin
      rdata = 32'h0;
      return;
    end
    if (wr) return;
    bits = 8 * size;
    v = (longint'(word) >> (8 * b)) % (longint'(1) << bits);
    if (!u && bits < 32 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits) + (longint'(1) << 32);
    rdata = 32'(v);
  endfunction

  // Called at posedge+1 with the bus idle; returns at posedge+1 with the DUT back in IDLE.
  task automatic run_txn(input string tag, input vec_t t);
    int n;
    int stall_low;
    int exp_cycles;
    logic is_err;
    is_err = (t.delay >= TO);
    exp_cycles = is_err ? TO : t.delay + 1;
    i_valid = 1'b1; i_mem_read = t.rd; i_mem_write = t.wr; i_is_unsigned = t.u;
    i_mascara = t.mask; i_addr = t.addr; i_wdata = t.wdata; i_mem_ack = 1'b0;
    @(negedge clk);
    check({tag, " start stall"}, 32'(o_stall), 32'(!t.exp_mis));
    check({tag, " start mem_en"}, 32'(o_mem_en), 0);
    next_cycle();
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_wdata = $urandom; i_addr = $urandom;
    if (t.exp_mis) begin
      @(negedge clk);
      check({tag, " misaligned pulse"}, 32'(o_misaligned), 1);
      check({tag, " fault mem_en/stall"}, {30'd0, o_mem_en, o_stall}, 0);
      check({tag, " fault rdata"}, o_rdata, t.exp_rdata);
      next_cycle();
      @(negedge clk);
      check({tag, " misaligned cleared"}, 32'(o_misaligned), 0);
      next_cycle();
      return;
    end
    n = 0;
    stall_low = 0;
    while (n <= TO + 3) begin
      i_mem_ack   = (n == t.delay);
      i_mem_rdata = (n == t.delay) ? t.word : $urandom;
      @(negedge clk);
      if (!o_mem_en) break;
      if (!o_stall) stall_low++;
      if (n == 0) begin
        check({tag, " we"}, 32'(o_mem_we), 32'(t.exp_we));
        check({tag, " mem_addr"}, 32'(o_mem_addr), t.addr >> 2);
        if (t.wr) check({tag, " mem_wdata"}, o_mem_wdata, t.exp_wd);
      end
      n++;
      next_cycle();
    end
    i_mem_ack = 1'b0;
    check({tag, " access cycles"}, 32'(n), 32'(exp_cycles));
    check({tag, " stall low in access"}, 32'(stall_low), 0);
    check({tag, " done stall"}, 32'(o_stall), 0);
    check({tag, " rdata_valid"}, 32'(o_rdata_valid), 32'(!t.wr && !is_err));
    check({tag, " bus_error"}, 32'(o_bus_error), 32'(is_err));
    check({tag, " rdata"}, o_rdata, t.exp_rdata);
    next_cycle();
    @(negedge clk);
    check({tag, " pulses cleared"}, {30'd0, o_rdata_valid, o_bus_error}, 0);
    check({tag, " rdata held"}, o_rdata, t.exp_rdata);
    next_cycle();
  endtask

  vec_t vecs[12];

  initial begin
    vec_t t;
    logic [31:0] prev;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h1000_0003, 32'h0, 32'h8011_2233, 2, 4'b0000, 32'h0, 1'b0, 32'hFFFF_FF80};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 2'b01, 32'h1000_0002, 32'h0, 32'h9ABC_1234, 0, 4'b0000, 32'h0, 1'b0, 32'h0000_9ABC};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'b01, 32'h1000_0002, 32'h0, 32'h9ABC_1234, 0, 4'b0000, 32'h0, 1'b0, 32'hFFFF_9ABC};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h2000_0001, 32'h0000_00A5, 32'h0, 1, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'hFFFF_9ABC};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_0002, 32'h0000_1234, 32'h0, 0, 4'b1100, 32'h1234_1234, 1'b0, 32'hFFFF_9ABC};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h3000_0002, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 1'b1, 32'hFFFF_9ABC};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h3000_0000, 32'h0, 32'h0, TO + 5, 4'b0000, 32'h0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0, 1, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_0041, 32'h0, 32'h0000_FF00, 3, 4'b0000, 32'h0, 1'b0, 32'h0000_00FF};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_0001, 32'h0000_5555, 32'h0, 0, 4'b0000, 32'h0, 1'b1, 32'h0000_00FF};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0008, 32'h0, 32'h1234_5678, TO - 1, 4'b0000, 32'h0, 1'b0, 32'h1234_5678};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 2'b00, 32'h0000_0010, 32'h0000_0011, 32'hFFFF_FFFF, 0, 4'b0001, 32'h1111_1111, 1'b0, 32'h1234_5678};

    i_reset = 1'b0; i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_is_unsigned = 1'b0; i_mascara = 2'b00; i_addr = '0; i_wdata = '0;
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    i_reset = 1'b1;
    next_cycle();

    foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Reset in the middle of an access, then a stray ack after release.
    i_valid = 1'b1; i_mem_read = 1'b1; i_mascara = 2'b10; i_addr = 32'h40; i_mem_ack = 1'b0;
    next_cycle();
    i_valid = 1'b0; i_mem_read = 1'b0;
    next_cycle();
    @(negedge clk);
    check("midreset in access", 32'(o_mem_en), 1);
    i_reset = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    i_reset = 1'b1;
    next_cycle();
    i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("stray ack pulses", {29'd0, o_rdata_valid, o_bus_error, o_mem_en}, 0);
    check("stray ack stall", 32'(o_stall), 0);
    next_cycle();
    i_mem_ack = 1'b0;
    @(negedge clk);
    check("stray ack rdata", o_rdata, 0);
    next_cycle();
    t = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 1, 4'b0000, 32'h0, 1'b0, 32'hCAFE_F00D};
    run_txn("post-reset load", t);
    model_rdata = 32'hCAFE_F00D;

    for (int k = 0; k < 150; k++) begin
      t.rd    = $urandom_range(0, 1);
      t.wr    = $urandom_range(0, 1);
      if (!t.rd && !t.wr) t.rd = 1'b1;
      t.u     = $urandom_range(0, 1);
      t.mask  = 2'($urandom_range(0, 3));
      t.addr  = $urandom;
      if ($urandom_range(0, 3) != 0) t.addr[1:0] = (t.mask == 2'b00) ? t.addr[1:0] : (t.mask == 2'b01) ? {t.addr[1], 1'b0} : 2'b00;
      t.wdata = $urandom;
      t.word  = $urandom;
      t.delay = ($urandom_range(0, 7) == 0) ? TO + 2 : $urandom_range(0, 4);
      prev = model_rdata;
      model(t.wr, t.u, t.mask, t.addr, t.wdata, t.word, t.delay, t.exp_we, t.exp_wd, t.exp_mis, model_rdata);
      t.exp_rdata = model_rdata;
      run_txn($sformatf("rnd%0d", k), t);
      if (t.exp_mis && prev !== model_rdata) check($sformatf("rnd%0d model hold", k), model_rdata, prev);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
